// File: rtl/sc_matmul_engine.sv
`default_nettype none
// ============================================================================
// Module   : sc_matmul_engine
// Brief    : Stochastic-computing matrix multiply engine.
//            LFSR-driven streams, AND-gate products, round-robin MUX adder.
// Revision : 1.0 - initial release
// ============================================================================
module sc_matmul_engine #(
  parameter int          BATCH_SIZE       = 4,
  parameter int          INPUT_FEATURES   = 4,
  parameter int          OUTPUT_FEATURES  = 4,
  parameter int          BINARY_PRECISION = 16,
  parameter int          MAX_CYCLES       = 1024,
  parameter logic [31:0] SEED_X           = 32'h1,
  parameter logic [31:0] SEED_W           = 32'hACE1,
  localparam int         CW               = $clog2(MAX_CYCLES + 1)
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_ni,
  input  logic                                                    start_i,
  output logic                                                    in_ready_o,
  input  logic [CW-1:0]                                           num_cycles_i,
  input  logic [BINARY_PRECISION*BATCH_SIZE*INPUT_FEATURES-1:0]   input_matrix_i,
  input  logic [BINARY_PRECISION*OUTPUT_FEATURES*INPUT_FEATURES-1:0] weight_matrix_i,
  output logic [CW*BATCH_SIZE*OUTPUT_FEATURES-1:0]                output_matrix_o,
  output logic                                                    out_valid_o,
  input  logic                                                    out_ready_i,
  output logic                                                    busy_o
);

  localparam int          M         = BATCH_SIZE;
  localparam int          N         = INPUT_FEATURES;
  localparam int          O         = OUTPUT_FEATURES;
  localparam int          WB        = BINARY_PRECISION;
  localparam int          SW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [M*N*WB-1:0]   x_q, x_d;
  logic [O*N*WB-1:0]   w_q, w_d;
  logic [CW-1:0]       len_q, len_d;
  logic [CW-1:0]       k_q, k_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [31:0]         lfsr_x_q, lfsr_x_d;
  logic [31:0]         lfsr_w_q, lfsr_w_d;
  logic                fresh_q, fresh_d;
  logic [CW-1:0]       acc_q [M*O];
  logic [CW-1:0]       acc_d [M*O];

  logic                accept;
  logic                last_cycle;
  logic [CW-1:0]       len_in;
  logic [WB-1:0]       rx;
  logic [WB-1:0]       rw;
  logic [N-1:0]        xrow [M];
  logic [N-1:0]        wrow [O];
  logic [M*O-1:0]      s;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  assign in_ready_o = (state_q == S_IDLE);
  // A zero-length run still presents its (empty) result one cycle after accept.
  assign out_valid_o = (state_q == S_DONE) && !fresh_q;
  assign busy_o      = (state_q == S_RUN) || (state_q == S_DONE);
  assign accept      = start_i && in_ready_o;
  assign last_cycle  = (k_q == (len_q - CW'(1)));
  assign len_in      = (num_cycles_i > CW'(MAX_CYCLES)) ? CW'(MAX_CYCLES) : num_cycles_i;
  assign rx          = lfsr_x_q[WB-1:0];
  assign rw          = lfsr_w_q[WB-1:0];

  for (genvar gm = 0; gm < M; gm++) begin : g_xrow
    for (genvar gn = 0; gn < N; gn++) begin : g_xcol
      assign xrow[gm][gn] = (rx < x_q[(gm*N+gn)*WB +: WB]);
    end
  end

  for (genvar go = 0; go < O; go++) begin : g_wrow
    for (genvar gn = 0; gn < N; gn++) begin : g_wcol
      assign wrow[go][gn] = (rw < w_q[(go*N+gn)*WB +: WB]);
    end
  end

  for (genvar gm = 0; gm < M; gm++) begin : g_prod_m
    for (genvar go = 0; go < O; go++) begin : g_prod_o
      assign s[gm*O+go] = xrow[gm][sel_q] & wrow[go][sel_q];
      assign output_matrix_o[(gm*O+go)*CW +: CW] = acc_q[gm*O+go];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = (len_in == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last_cycle) state_d = S_DONE;
      S_DONE: if (out_valid_o && out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d      = x_q;
    w_d      = w_q;
    len_d    = len_q;
    k_d      = k_q;
    sel_d    = sel_q;
    lfsr_x_d = lfsr_x_q;
    lfsr_w_d = lfsr_w_q;
    fresh_d  = 1'b0;
    acc_d    = acc_q;
    if (accept) begin
      x_d      = input_matrix_i;
      w_d      = weight_matrix_i;
      len_d    = len_in;
      k_d      = '0;
      sel_d    = '0;
      lfsr_x_d = SEED_X;
      lfsr_w_d = SEED_W;
      fresh_d  = (len_in == '0);
      for (int i = 0; i < M*O; i++) acc_d[i] = '0;
    end else if (state_q == S_RUN) begin
      lfsr_x_d = lfsr_step(lfsr_x_q);
      lfsr_w_d = lfsr_step(lfsr_w_q);
      k_d      = k_q + CW'(1);
      // Round-robin MUX select, equivalent to k mod N without a divider.
      sel_d    = (sel_q == SW'(N-1)) ? '0 : sel_q + SW'(1);
      for (int i = 0; i < M*O; i++) acc_d[i] = acc_q[i] + CW'(s[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      w_q      <= '0;
      len_q    <= '0;
      k_q      <= '0;
      sel_q    <= '0;
      lfsr_x_q <= SEED_X;
      lfsr_w_q <= SEED_W;
      fresh_q  <= 1'b0;
      for (int i = 0; i < M*O; i++) acc_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      w_q      <= w_d;
      len_q    <= len_d;
      k_q      <= k_d;
      sel_q    <= sel_d;
      lfsr_x_q <= lfsr_x_d;
      lfsr_w_q <= lfsr_w_d;
      fresh_q  <= fresh_d;
      for (int i = 0; i < M*O; i++) acc_q[i] <= acc_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sc_matmul_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_matmul_engine
// Brief    : Self-checking bench for sc_matmul_engine against a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_matmul_engine;

  localparam int M    = 4;
  localparam int N    = 4;
  localparam int O    = 4;
  localparam int WB   = 16;
  localparam int MAXC = 1024;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [31:0] SEED_X = 32'h1;
  localparam logic [31:0] SEED_W = 32'hACE1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                in_ready;
  logic [CW-1:0]       num_cycles;
  logic [WB*M*N-1:0]   input_matrix;
  logic [WB*O*N-1:0]   weight_matrix;
  logic [CW*M*O-1:0]   output_matrix;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  int checks = 0;
  int errors = 0;

  logic [WB-1:0] xv [M][N];
  logic [WB-1:0] wv [O][N];
  logic [CW-1:0] exp_acc [M][O];

  always #5 clk = ~clk;

  sc_matmul_engine #(
    .BATCH_SIZE(M), .INPUT_FEATURES(N), .OUTPUT_FEATURES(O),
    .BINARY_PRECISION(WB), .MAX_CYCLES(MAXC), .SEED_X(SEED_X), .SEED_W(SEED_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_ready_o(in_ready),
    .num_cycles_i(num_cycles), .input_matrix_i(input_matrix),
    .weight_matrix_i(weight_matrix), .output_matrix_o(output_matrix),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  // Reference: stochastic streams evaluated cycle by cycle from the LFSR sequence.
  task automatic model(input int len);
    logic [31:0] lx, lw;
    logic [WB-1:0] rx, rw;
    int sel;
    if (len > MAXC) len = MAXC;
    for (int m = 0; m < M; m++) for (int o = 0; o < O; o++) exp_acc[m][o] = '0;
    lx = SEED_X;
    lw = SEED_W;
    for (int c = 0; c < len; c++) begin
      rx  = lx[WB-1:0];
      rw  = lw[WB-1:0];
      sel = c % N;
      for (int m = 0; m < M; m++)
        for (int o = 0; o < O; o++)
          if (rx < xv[m][sel] && rw < wv[o][sel]) exp_acc[m][o] = exp_acc[m][o] + 1'b1;
      lx = (lx >> 1) ^ (lx[0] ? 32'h8020_0003 : 32'h0);
      lw = (lw >> 1) ^ (lw[0] ? 32'h8020_0003 : 32'h0);
    end
  endtask

  task automatic randomize_mats();
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) xv[m][n] = WB'($urandom);
    for (int o = 0; o < O; o++) for (int n = 0; n < N; n++) wv[o][n] = WB'($urandom);
  endtask

  task automatic load(input int len);
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++)
      input_matrix[(m*N+n)*WB +: WB] = xv[m][n];
    for (int o = 0; o < O; o++) for (int n = 0; n < N; n++)
      weight_matrix[(o*N+n)*WB +: WB] = wv[o][n];
    num_cycles = CW'(len);
  endtask

  task automatic accept();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (!out_valid && cycles < budget) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (output_matrix !== '0) begin errors++; $display("FAIL reset_out got %h want 0", output_matrix); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero_inputs();
    int cyc; bit bok;
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) xv[m][n] = '0;
    for (int o = 0; o < O; o++) for (int n = 0; n < N; n++) wv[o][n] = '1;
    load(256);
    accept();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zx_ready got %b want 0", in_ready); end
    wait_valid(300, cyc, bok);
    checks++; if (cyc !== 256) begin errors++; $display("FAIL zx_latency got %0d want 256", cyc); end
    checks++; if (output_matrix !== '0) begin errors++; $display("FAIL zx_out got %h want 0", output_matrix); end
    handshake();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zx_idle got %b want 1", in_ready); end
  endtask

  task automatic test_zero_weights();
    int cyc; bit bok;
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) xv[m][n] = '1;
    for (int o = 0; o < O; o++) for (int n = 0; n < N; n++) wv[o][n] = '0;
    load(1000);
    accept();
    wait_valid(1100, cyc, bok);
    checks++; if (cyc !== 1000) begin errors++; $display("FAIL zw_latency got %0d want 1000", cyc); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL zw_busy_run got low want high"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zw_busy_done got %b want 1", busy); end
    checks++; if (output_matrix !== '0) begin errors++; $display("FAIL zw_out got %h want 0", output_matrix); end
    handshake();
  endtask

  task automatic test_bit_exact();
    int cyc; bit bok;
    logic [CW-1:0] got;
    for (int r = 0; r < 3; r++) begin
      randomize_mats();
      if (r == 2) begin xv[0][0] = '1; wv[0][0] = '1; end
      model(512);
      load(512);
      accept();
      wait_valid(600, cyc, bok);
      checks++; if (cyc !== 512) begin errors++; $display("FAIL bx_latency got %0d want 512", cyc); end
      for (int m = 0; m < M; m++) for (int o = 0; o < O; o++) begin
        got = output_matrix[(m*O+o)*CW +: CW];
        checks++;
        if (got !== exp_acc[m][o]) begin
          errors++; $display("FAIL bx_y[%0d][%0d] run %0d got %0d want %0d", m, o, r, got, exp_acc[m][o]);
        end
      end
      handshake();
    end
  endtask

  task automatic test_back_pressure();
    int cyc; bit bok;
    logic [CW*M*O-1:0] snap;
    logic [CW-1:0] got;
    randomize_mats();
    model(64);
    load(64);
    accept();
    wait_valid(100, cyc, bok);
    checks++; if (cyc !== 64) begin errors++; $display("FAIL bp_latency got %0d want 64", cyc); end
    snap = output_matrix;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      num_cycles = CW'(5);
      input_matrix = ~input_matrix;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b want 1", i, out_valid); end
      checks++; if (output_matrix !== snap) begin errors++; $display("FAIL bp_hold cyc %0d got %h want %h", i, output_matrix, snap); end
    end
    // start coincident with the result handshake must not launch a run
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_simul_busy got %b want 0", busy); end
    for (int m = 0; m < M; m++) for (int o = 0; o < O; o++) begin
      got = output_matrix[(m*O+o)*CW +: CW];
      checks++;
      if (got !== exp_acc[m][o]) begin
        errors++; $display("FAIL bp_retain[%0d][%0d] got %0d want %0d", m, o, got, exp_acc[m][o]);
      end
    end
  endtask

  task automatic test_back_to_back_zero_len();
    int cyc; bit bok;
    load(0);
    accept();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL z0_busy got %b want 1", busy); end
    wait_valid(10, cyc, bok);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL z0_latency got %0d want 1", cyc); end
    checks++; if (output_matrix !== '0) begin errors++; $display("FAIL z0_out got %h want 0", output_matrix); end
    handshake();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL z0_idle got %b want 1", in_ready); end
  endtask

  task automatic test_clamp();
    int cyc; bit bok;
    logic [CW-1:0] got;
    randomize_mats();
    model(MAXC + 5);
    load(MAXC + 5);
    accept();
    wait_valid(1200, cyc, bok);
    checks++; if (cyc !== MAXC) begin errors++; $display("FAIL clamp_latency got %0d want %0d", cyc, MAXC); end
    for (int m = 0; m < M; m++) for (int o = 0; o < O; o++) begin
      got = output_matrix[(m*O+o)*CW +: CW];
      checks++;
      if (got !== exp_acc[m][o]) begin
        errors++; $display("FAIL clamp_y[%0d][%0d] got %0d want %0d", m, o, got, exp_acc[m][o]);
      end
    end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit bok;
    logic [CW-1:0] got;
    randomize_mats();
    model(512);
    load(512);
    accept();
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", out_valid); end
    checks++; if (output_matrix !== '0) begin errors++; $display("FAIL mr_out got %h want 0", output_matrix); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b want 0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_ready got %b want 1", in_ready); end
    accept();
    wait_valid(600, cyc, bok);
    checks++; if (cyc !== 512) begin errors++; $display("FAIL mr_latency got %0d want 512", cyc); end
    for (int m = 0; m < M; m++) for (int o = 0; o < O; o++) begin
      got = output_matrix[(m*O+o)*CW +: CW];
      checks++;
      if (got !== exp_acc[m][o]) begin
        errors++; $display("FAIL mr_y[%0d][%0d] got %0d want %0d", m, o, got, exp_acc[m][o]);
      end
    end
    handshake();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    num_cycles = '0;
    input_matrix = '0;
    weight_matrix = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_zero_inputs();
    test_zero_weights();
    test_bit_exact();
    test_back_pressure();
    test_back_to_back_zero_len();
    test_clamp();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
